note_sequencer: RTL
===================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 16: number of pattern steps (power of 2, index width SW = log2(STEPS)).
REQ-002 SHALL have parameter TICK_DIV, default 20480: clk cycles per sequencer tick (1 ms at 20.48 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 20.48 MHz, the single clock domain.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  pattern write strobe.
REQ-006 SHALL have port wr_addr  input  SW  pattern step address.
REQ-007 SHALL have port wr_data  input  21  step entry: [20] rest, [19:12] len in ticks, [11:0] osc count.
REQ-008 SHALL have port start  input  1  single-cycle start request.
REQ-009 SHALL have port stop  input  1  single-cycle stop request.
REQ-010 SHALL have port loop_en  input  1  wrap to step 0 after the last step.
REQ-011 SHALL have port seq_len  input  SW+1  active steps, 1..STEPS.
REQ-012 SHALL have port gate_ticks  input  8  ticks trig stays high within a step.
REQ-013 SHALL have port osc_count  output  12  oscillator period to synth.
REQ-014 SHALL have port trig  output  1  ADSR gate to synth (level).
REQ-015 SHALL have port busy  output  1  high in FETCH or NOTE.
REQ-016 SHALL have port step_idx  output  SW  current step.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a non-looping pattern ends.

Function
REQ-018 SHALL store STEPS entries in a register array; wr_en writes wr_data to wr_addr on the rising clk edge in any state.
REQ-019 SHALL implement states IDLE, FETCH, NOTE.
REQ-020 SHALL, in IDLE, on start with seq_len in 1..STEPS and stop low, go to FETCH with step_idx=0 and clear the tick prescaler.
REQ-021 SHALL ignore start when seq_len=0, when seq_len>STEPS, or when busy.
REQ-022 SHALL, in FETCH (one cycle), read entry[step_idx] and load osc_count=count (rest: hold previous osc_count), remaining=max(len,1), elapsed=0, then go to NOTE.
REQ-023 SHALL drive osc_count and trig valid 2 clk cycles after the cycle start is sampled.
REQ-024 SHALL generate a one-cycle tick every TICK_DIV clk cycles from a prescaler counting 0..TICK_DIV-1.
REQ-025 SHALL, in NOTE on each tick, decrement remaining and increment elapsed (saturating at 255).
REQ-026 SHALL drive trig=1 in NOTE when the step is not a rest and elapsed<gate_ticks; otherwise trig=0; gate_ticks=0 gives trig=0.
REQ-027 SHALL, on the tick where remaining reaches 0, advance: if step_idx<seq_len-1, increment step_idx and go to FETCH; else if loop_en, step_idx=0 and FETCH; else IDLE and pulse done.
REQ-028 SHALL keep trig continuously high across a step boundary when consecutive steps both hold trig (legato, gate_ticks>=len).
REQ-029 SHALL, on stop in any state, enter IDLE on the next edge with trig=0 and no done pulse; stop wins over simultaneous start or step advance.
REQ-030 SHALL make writes to a step take effect at its next FETCH; a same-cycle write and FETCH of the same address reads the old entry.
REQ-031 SHALL sample seq_len and loop_en only at step advance.

Reset
REQ-032 SHALL, on rst, asynchronously set state=IDLE, osc_count=0, trig=0, busy=0, done=0, step_idx=0, and clear prescaler, remaining and elapsed.
REQ-033 SHALL leave pattern memory unreset (contents undefined until written).

Structure
REQ-034 SHALL take the state encoding and the step-entry field offsets (rest, len, count) from the shared synth package.
REQ-035 SHALL contain one sub-module, tick_prescaler, holding the TICK_DIV counter with a synchronous clear.

Verification (TICK_DIV=4, STEPS=16)
REQ-036 SHALL check: write steps 0..2 = {0,3,100},{0,2,200},{1,2,300}; seq_len=3, gate_ticks=1, loop_en=0; start -> osc_count 100, 200, 200 (rest holds); trig high 4 cycles per non-rest step; done one cycle after step 2; busy low after.
REQ-037 SHALL check: same pattern with loop_en=1 -> step_idx sequence 0,1,2,0,1; no done pulse.
REQ-038 SHALL check: stop asserted mid-step 1 together with start -> IDLE next edge, trig=0, done=0.
REQ-039 SHALL check: len=0 entry -> step lasts exactly 1 tick; seq_len=0 start -> busy stays 0.
REQ-040 SHALL check: gate_ticks=255 with len 3,3 -> trig stays high continuously across the step boundary.
REQ-041 SHALL check: rst asserted mid-NOTE -> outputs zero immediately without a clock edge; memory contents retained after release.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// Shared synth definitions: sequencer state encoding and step-entry field layout.
// Entry layout: [20] rest, [19:12] length in ticks, [11:0] oscillator count.
package note_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_NOTE  = 2'd2
    } seq_state_t;

    localparam int ENTRY_W   = 21;
    localparam int REST_BIT  = 20;
    localparam int LEN_LSB   = 12;
    localparam int LEN_W     = 8;
    localparam int COUNT_LSB = 0;
    localparam int COUNT_W   = 12;

    typedef struct packed {
        logic               rest;
        logic [LEN_W-1:0]   len;
        logic [COUNT_W-1:0] count;
    } step_entry_t;

    function automatic step_entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
        step_entry_t e;
        e.rest  = raw[REST_BIT];
        e.len   = raw[LEN_LSB +: LEN_W];
        e.count = raw[COUNT_LSB +: COUNT_W];
        return e;
    endfunction

endpackage

// File: rtl/note_sequencer_tick_prescaler.sv
// Free-running tick divider: one-cycle tick every TICK_DIV clocks, count 0..TICK_DIV-1.
// Tick is combinational on the terminal count; clr restarts the count at 0 on the next edge.
module tick_prescaler #(
    parameter int TICK_DIV = 20480
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: plays a stored pattern of notes/rests, driving osc_count and an ADSR gate.
// Latency: outputs valid two cycles after start is sampled; no backpressure, stop aborts at once.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int STEPS    = 16,
    parameter int TICK_DIV = 20480,
    localparam int SW      = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [SW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [SW:0]        seq_len,
    input  logic [7:0]         gate_ticks,
    output logic [COUNT_W-1:0] osc_count,
    output logic               trig,
    output logic               busy,
    output logic [SW-1:0]      step_idx,
    output logic               done
);

    logic [ENTRY_W-1:0] mem [STEPS];
    seq_state_t         state;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   elapsed;
    logic               cur_rest;
    logic               tick;
    logic               start_ok;
    logic               last_step;
    logic [SW:0]        next_idx;
    step_entry_t        entry;

    // Pattern memory is deliberately unreset; writes land on the edge, so a
    // FETCH of the same address in that cycle still sees the old entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign entry     = unpack_entry(mem[step_idx]);
    assign start_ok  = (state == ST_IDLE) && start && !stop &&
                       (seq_len != '0) && (seq_len <= (SW+1)'(STEPS));
    assign next_idx  = {1'b0, step_idx} + (SW+1)'(1);
    assign last_step = !(next_idx < seq_len);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            osc_count <= '0;
            trig      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
            remaining <= '0;
            elapsed   <= '0;
            cur_rest  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
                trig  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            state    <= ST_FETCH;
                            step_idx <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (!entry.rest) begin
                            osc_count <= entry.count;
                        end
                        remaining <= (entry.len == '0) ? LEN_W'(1) : entry.len;
                        elapsed   <= '0;
                        cur_rest  <= entry.rest;
                        trig      <= !entry.rest && (gate_ticks != '0);
                        state     <= ST_NOTE;
                    end
                    ST_NOTE: begin
                        // Gate follows elapsed one cycle late, which also carries a held
                        // gate through the following FETCH for legato steps.
                        trig <= !cur_rest && (elapsed < gate_ticks);
                        if (tick) begin
                            remaining <= remaining - LEN_W'(1);
                            if (elapsed != '1) begin
                                elapsed <= elapsed + LEN_W'(1);
                            end
                            if (remaining == LEN_W'(1)) begin
                                if (!last_step) begin
                                    step_idx <= next_idx[SW-1:0];
                                    state    <= ST_FETCH;
                                end else if (loop_en) begin
                                    step_idx <= '0;
                                    state    <= ST_FETCH;
                                end else begin
                                    state <= ST_IDLE;
                                    busy  <= 1'b0;
                                    trig  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
